dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/mem_pkg.sv | 25 ++
 rtl/dmem_array.sv | 42 ++++
 rtl/dmem_responder.sv | 125 ++++++++++++
 tb/tb_dmem_responder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the data-memory responder: FSM states and request/response bundles.
package mem_pkg;

   localparam int unsigned XLEN = 32;
   localparam int unsigned BEW  = XLEN / 8;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StResp = 2'd2
   } state_e;

   typedef struct packed {
      logic            we;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] wdata;
      logic [BEW-1:0]  be;
   } req_t;

   typedef struct packed {
      logic [XLEN-1:0] rdata;
      logic            err;
   } rsp_t;

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: one byte-enabled write port, one registered read port.
// Contents are intentionally not reset.
module dmem_array
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned ADDR_W      = 8
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [XLEN-1:0]   wdata_i,
   input  logic [BEW-1:0]    be_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [XLEN-1:0]   rdata_o
);

   logic [XLEN-1:0] mem_q [DEPTH_WORDS];
   logic [XLEN-1:0] rdata_q;

   // Byte-masked write; each enable bit covers one byte lane.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int i = 0; i < int'(BEW); i++) begin
            if (be_i[i]) begin
               mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
         end
      end
   end

   // Read data is captured only on an enabled read, so it holds until the next load.
   always_ff @(posedge clk_i) begin
      if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with fixed response latency.
// Stores commit and loads sample at the acceptance edge; the FSM only times the response.
module dmem_responder
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   input  logic [BEW-1:0]  req_be,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_err
);

   localparam int unsigned AddrW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0]  LatLoad = 4'(LATENCY - 1);

   state_e          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            err_q, err_d;
   logic            store_q, store_d;
   req_t            req;
   rsp_t            rsp;
   logic            accept;
   logic            legal;
   logic [XLEN-1:0] arr_rdata;

   assign req       = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
   assign req_ready = (state_q == StIdle) && !rst;
   assign accept    = req_valid && req_ready;
   assign legal     = (req.addr[1:0] == 2'b00) &&
                      ({2'b00, req.addr[XLEN-1:2]} < DEPTH_WORDS);

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .ADDR_W      (AddrW)
   ) u_array (
      .clk_i   (clk),
      .we_i    (accept && req.we && legal),
      .waddr_i (req.addr[AddrW+1:2]),
      .wdata_i (req.wdata),
      .be_i    (req.be),
      .re_i    (accept && !req.we && legal),
      .raddr_i (req.addr[AddrW+1:2]),
      .rdata_o (arr_rdata)
   );

   // Next-state: capture request kind on accept, count down latency, wait for handshake.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      store_d = store_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               err_d   = !legal;
               store_d = req.we;
               if (LATENCY <= 1) begin
                  state_d = StResp;
                  cnt_d   = 4'd0;
               end else begin
                  state_d = StWait;
                  cnt_d   = LatLoad;
               end
            end
         end
         StWait: begin
            if (cnt_q <= 4'd1) begin
               state_d = StResp;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               state_d = StIdle;
               err_d   = 1'b0;
               store_d = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State register with synchronous reset; a pending response is simply dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         err_q   <= 1'b0;
         store_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         store_q <= store_d;
      end
   end

   // Response outputs: data only for a successful load, everything zero outside RESP.
   always_comb begin
      rsp = '0;
      if (!rst && (state_q == StResp)) begin
         rsp.err = err_q;
         if (!err_q && !store_q) begin
            rsp.rdata = arr_rdata;
         end
      end
   end

   assign rsp_valid = !rst && (state_q == StResp);
   assign rsp_rdata = rsp.rdata;
   assign rsp_err   = rsp.err;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table plus backpressure and reset sequences.
module tb_dmem_responder;

   localparam int unsigned Depth = 256;
   localparam int unsigned Lat   = 2;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int total = 0;
   int bad   = 0;

   dmem_responder #(
      .DEPTH_WORDS (Depth),
      .LATENCY     (Lat)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_be    (req_be),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Present a request and wait (bounded) until it is accepted; ok=0 on timeout.
   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input string tag, output bit ok);
      int n;
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_be    = be;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      ok = req_ready;
      if (!ok) begin
         chk({tag, " ready_timeout"}, 32'(req_ready), 32'd1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   // Full transaction: latency, response contents, optional backpressure, handshake.
   task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic [31:0] exp_rdata,
                          input logic exp_err, input int hold, input string tag);
      bit ok;
      int n;
      issue(we, addr, wdata, be, tag, ok);
      if (!ok) return;
      n = 1;  // acceptance edge already taken
      while (!rsp_valid && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk({tag, " latency"}, 32'(n), 32'(Lat));
      chk({tag, " rdata"}, rsp_rdata, exp_rdata);
      chk({tag, " err"}, 32'(rsp_err), 32'(exp_err));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         chk({tag, " hold_valid"}, 32'(rsp_valid), 32'd1);
         chk({tag, " hold_rdata"}, rsp_rdata, exp_rdata);
         chk({tag, " hold_req_ready"}, 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      #1;
      chk({tag, " ready_in_resp"}, 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      chk({tag, " valid_after_hs"}, 32'(rsp_valid), 32'd0);
      chk({tag, " ready_after_hs"}, 32'(req_ready), 32'd1);
   endtask

   // Accept a request, then reset while it sits in WAIT; no response may follow.
   task automatic rst_in_wait(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, input string tag);
      bit ok;
      issue(we, addr, wdata, be, tag, ok);
      if (!ok) return;
      chk({tag, " wait_valid"}, 32'(rsp_valid), 32'd0);
      rst = 1'b1;
      #1;
      chk({tag, " rst_req_ready"}, 32'(req_ready), 32'd0);
      repeat (2) begin
         @(posedge clk);
         #1;
         chk({tag, " rst_req_ready"}, 32'(req_ready), 32'd0);
         chk({tag, " rst_valid"}, 32'(rsp_valid), 32'd0);
      end
      rst = 1'b0;
      #1;
      chk({tag, " post_rst_ready"}, 32'(req_ready), 32'd1);
      repeat (Lat + 3) begin
         @(posedge clk);
         #1;
         chk({tag, " no_rsp"}, 32'(rsp_valid), 32'd0);
      end
   endtask

   initial begin
      vecs[0]  = '{1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
      vecs[1]  = '{1'b0, 32'h010, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b1, 32'h010, 32'h000000AA, 4'h1, 32'h0,        1'b0};
      vecs[3]  = '{1'b0, 32'h010, 32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
      vecs[4]  = '{1'b1, 32'h000, 32'h12345678, 4'hF, 32'h0,        1'b0};
      vecs[5]  = '{1'b0, 32'h013, 32'h0,        4'h0, 32'h0,        1'b1};
      vecs[6]  = '{1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
      vecs[7]  = '{1'b1, 32'h002, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
      vecs[8]  = '{1'b0, 32'h000, 32'h0,        4'h0, 32'h12345678, 1'b0};
      vecs[9]  = '{1'b1, 32'h3FC, 32'h00000000, 4'hF, 32'h0,        1'b0};
      vecs[10] = '{1'b1, 32'h3FC, 32'hA1B2C3D4, 4'h6, 32'h0,        1'b0};
      vecs[11] = '{1'b0, 32'h3FC, 32'h0,        4'h0, 32'h00B2C300, 1'b0};

      rst       = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = 32'h0;
      req_wdata = 32'h0;
      req_be    = 4'h0;
      rsp_ready = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk("reset req_ready", 32'(req_ready), 32'd0);
      chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
      chk("reset rsp_rdata", rsp_rdata, 32'd0);
      chk("reset rsp_err", 32'(rsp_err), 32'd0);
      rst = 1'b0;
      #1;
      chk("post reset req_ready", 32'(req_ready), 32'd1);

      for (int i = 0; i < 12; i++) begin
         run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
                 vecs[i].exp_rdata, vecs[i].exp_err, 0, $sformatf("vec%0d", i));
      end

      // Backpressure on a load response.
      run_txn(1'b0, 32'h010, 32'h0, 4'h0, 32'hDEADBEAA, 1'b0, 5, "bp");

      // Reset during WAIT of a load, then of a store whose write must survive.
      rst_in_wait(1'b0, 32'h010, 32'h0, 4'h0, "rstw_load");
      rst_in_wait(1'b1, 32'h020, 32'hCAFEF00D, 4'hF, "rstw_store");
      run_txn(1'b0, 32'h020, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 0, "after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
